// File: rtl/a5_sequencer.sv
// A5/1 control sequencer: drives three external LFSRs through clear, key, frame and mix phases,
// then streams keystream bits over a valid/ready handshake.
module a5_sequencer #(
    parameter int unsigned KEY_BITS   = 64,
    parameter int unsigned FRAME_BITS = 22,
    parameter int unsigned MIX_CYCLES = 100,
    parameter int unsigned KS_BITS    = 228
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KEY_BITS-1:0]   key,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic [2:0]            clock_bits,
    input  logic [2:0]            lfsr_q,
    output logic                  lfsr_load,
    output logic [2:0]            lfsr_clk_en,
    output logic                  lfsr_d,
    output logic                  busy,
    output logic                  ks_valid,
    output logic                  ks_bit,
    input  logic                  ks_ready,
    output logic                  done
);

    localparam int unsigned MixSteps = MIX_CYCLES + 1;
    localparam int unsigned MaxA     = (KEY_BITS > MixSteps) ? KEY_BITS : MixSteps;
    localparam int unsigned MaxB     = (MaxA > KS_BITS) ? MaxA : KS_BITS;
    localparam int unsigned CntMax   = (MaxB > FRAME_BITS) ? MaxB : FRAME_BITS;
    localparam int unsigned CntW     = (CntMax > 2) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] KeyLast   = CntW'(KEY_BITS - 1);
    localparam logic [CntW-1:0] FrameLast = CntW'(FRAME_BITS - 1);
    localparam logic [CntW-1:0] MixLast   = CntW'(MixSteps - 1);
    localparam logic [CntW-1:0] KsLast    = CntW'(KS_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StKey,
        StFrame,
        StMix,
        StStream
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [KEY_BITS-1:0]   key_sr_q, key_sr_d;
    logic [FRAME_BITS-1:0] frame_sr_q, frame_sr_d;
    logic                  done_q, done_d;

    logic       maj;
    logic [2:0] maj_en;

    // A register shifts when its clocking tap agrees with the majority; at least two always do.
    always_comb begin
        maj    = (clock_bits[0] & clock_bits[1]) | (clock_bits[0] & clock_bits[2]) |
                 (clock_bits[1] & clock_bits[2]);
        maj_en = {clock_bits[2] == maj, clock_bits[1] == maj, clock_bits[0] == maj};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_sr_d    = key_sr_q;
        frame_sr_d  = frame_sr_q;
        done_d      = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_clk_en = 3'b000;
        lfsr_d      = 1'b0;
        ks_valid    = 1'b0;
        busy        = 1'b1;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    key_sr_d   = key;
                    frame_sr_d = frame;
                    cnt_d      = '0;
                    state_d    = StClear;
                end
            end
            StClear: begin
                lfsr_load = 1'b1;
                cnt_d     = '0;
                state_d   = StKey;
            end
            StKey: begin
                lfsr_clk_en = 3'b111;
                lfsr_d      = key_sr_q[0];
                key_sr_d    = key_sr_q >> 1;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == KeyLast) begin
                    cnt_d   = '0;
                    state_d = StFrame;
                end
            end
            StFrame: begin
                lfsr_clk_en = 3'b111;
                lfsr_d      = frame_sr_q[0];
                frame_sr_d  = frame_sr_q >> 1;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == FrameLast) begin
                    cnt_d   = '0;
                    state_d = StMix;
                end
            end
            StMix: begin
                lfsr_clk_en = maj_en;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == MixLast) begin
                    cnt_d   = '0;
                    state_d = StStream;
                end
            end
            StStream: begin
                ks_valid = 1'b1;
                // A stalled consumer freezes the LFSRs so the offered bit stays put.
                if (ks_ready) begin
                    lfsr_clk_en = maj_en;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == KsLast) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            key_sr_q   <= '0;
            frame_sr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_sr_q   <= key_sr_d;
            frame_sr_q <= frame_sr_d;
            done_q     <= done_d;
        end
    end

    assign done   = done_q;
    assign ks_bit = ks_valid & (^lfsr_q);

endmodule

// File: doc/a5_sequencer.md
# a5_sequencer

Control sequencer for the A5/1 keystream datapath. It drives the three shared LFSR instances (R1 19 bits, R2 22 bits, R3 23 bits) through four phases:

- register clear;
- 64-bit key injection;
- 22-bit frame-number injection;
- majority-clocked mixing.

It then streams keystream bits to a consumer over a valid/ready handshake. It sits between the cipher's host-facing register block and the LFSR datapath.

## Interface
Parameters:
- KEY_BITS, 64, number of key bits injected, LSB first.
- FRAME_BITS, 22, number of frame bits injected, LSB first.
- MIX_CYCLES, 100, discarded majority-clocked steps. The block executes MIX_CYCLES+1 steps before the first output.
- KS_BITS, 228, keystream bits delivered per start.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a session. Sampled only in IDLE.
- key  in  KEY_BITS  session key. Captured on accepted start.
- frame  in  FRAME_BITS  frame number. Captured on accepted start.
- clock_bits  in  3  clocking-tap bit of R1/R2/R3 (index 0 = R1).
- lfsr_q  in  3  MSB output of R1/R2/R3.
- lfsr_load  out  1  clear all three LFSRs.
- lfsr_clk_en  out  3  per-register shift enable.
- lfsr_d  out  1  bit XORed into feedback (shared by all three LFSRs).
- busy  out  1  high from CLEAR through the end of STREAM.
- ks_valid  out  1  keystream bit available.
- ks_bit  out  1  keystream bit, equal to ^lfsr_q.
- ks_ready  in  1  consumer accepts ks_bit.
- done  out  1  one-cycle pulse after the final accepted bit.

## Operation
- States: IDLE, CLEAR, KEY, FRAME, MIX, STREAM. Counter width is clog2(max(KEY_BITS, MIX_CYCLES+1, KS_BITS)).
- Majority function: maj = (c0&c1)|(c0&c2)|(c1&c2), where c = clock_bits. In majority mode, lfsr_clk_en[i] = (clock_bits[i] == maj), so at least two registers shift every step.
- IDLE: all outputs 0. On start=1, latch key and frame into internal shift registers, then go to CLEAR.
- CLEAR (1 cycle): lfsr_load=1, lfsr_clk_en=0. Next state is KEY.
- KEY (KEY_BITS cycles):
  - lfsr_clk_en=3'b111.
  - Cycle n drives lfsr_d=key[n].
  - After n=KEY_BITS-1, go to FRAME.
- FRAME (FRAME_BITS cycles): same as KEY, with lfsr_d=frame[n]. Then go to MIX.
- MIX (MIX_CYCLES+1 cycles): lfsr_d=0, majority clocking. Then go to STREAM.
- STREAM:
  - ks_valid=1 and ks_bit=^lfsr_q (combinational from the current LFSR state).
  - lfsr_d=0.
  - When ks_valid&ks_ready, apply majority clocking and increment the bit counter.
  - When ks_ready=0, lfsr_clk_en=0 and the LFSR state is held.
  - After the KS_BITS-th accepted bit, go to IDLE and pulse done in that first IDLE cycle.
- start while busy: ignored. A new key or frame cannot corrupt the session in progress.
- start in the same cycle as the done pulse (IDLE): accepted.
- reset in any state: next cycle is IDLE with every output 0. The LFSR contents are left as-is and are cleared by the next CLEAR.

## Timing
- Reset values: lfsr_load=0, lfsr_clk_en=0, lfsr_d=0, busy=0, ks_valid=0, done=0. ks_bit is 0 whenever ks_valid=0.
- Phase schedule for start accepted at cycle T, with defaults:
  - CLEAR at T+1.
  - KEY at T+2..T+65.
  - FRAME at T+66..T+87.
  - MIX at T+88..T+188.
  - First ks_valid at T+189.
- With ks_ready held at 1: last bit accepted at T+416, done=1 at T+417, busy=0 at T+417.
- Latency from start to first keystream bit: 189 cycles. Backpressure adds exactly one cycle per stalled cycle.
- All state and control outputs are registered state decodes. lfsr_clk_en and ks_bit may depend combinationally on clock_bits, lfsr_q and ks_ready.

## Test plan
- Reference vector:
  - Stimulus: key=64'hEFCDAB8967452312 (byte 0x12 first, LSB first within byte), frame=22'h134, ks_ready=1.
  - Required response: the first 114 bits, MSB-first per byte, equal 534EAA582FE8151AB6E1855A728C00 (last byte's low 6 bits don't-care). The next 114 bits equal 24FD35A35D5FB6526D32F906DF1AC0.
- Phase timing:
  - Stimulus: start at cycle T.
  - Required response: lfsr_load only at T+1. lfsr_clk_en=111 for T+2..T+87. First ks_valid at T+189. done only at T+417.
- Backpressure:
  - Stimulus: reference vector with ks_ready toggled pseudo-randomly.
  - Required response: identical 228-bit stream. lfsr_clk_en=000 on every cycle with ks_ready=0. done delayed by exactly the number of stalled cycles.
- start while busy:
  - Stimulus: pulse start with a different key at T+50 and at T+300.
  - Required response: stream unchanged from the reference vector, and no session restart.
- Reset mid-operation:
  - Stimulus: assert reset during MIX, then start again with the reference vector.
  - Required response: all outputs 0 the cycle after reset. Second session produces the exact reference stream.
- Majority check:
  - Stimulus: in MIX/STREAM, drive clock_bits with all 8 combinations from the bench model.
  - Required response: lfsr_clk_en = 111 for 000 and 111. For every other combination, exactly the two matching registers are enabled.
